controle_atuadores: RTL and testbench

Sequencer between the wall-following navigation FSM and the robot's physical actuators. It takes level requests `avancar`, `girar` and `remover`, arbitrates them onto one shared drive train and debris arm, and plays each accepted request as a fixed-duration, timed actuator sequence. It sits directly below the navigation FSM and drives the motor bridges and arm driver.

---
 rtl/controle_atuadores_pkg.sv | 23 ++
 rtl/controle_atuadores_temporizador.sv | 25 ++
 rtl/controle_atuadores.sv | 120 ++++++++++++
 tb/tb_controle_atuadores.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_atuadores_pkg.sv
// controle_atuadores_pkg: state enum and actuator encodings shared by the actuator sequencer
package controle_pkg;

    // State names carry an E_ prefix so they do not collide with the arm encodings below
    typedef enum logic [2:0] {
        E_OCIOSO,
        E_AVANCA,
        E_GIRA,
        E_BRACO_DESCE,
        E_VARRE,
        E_BRACO_SOBE,
        E_PAUSA
    } estado_t;

    localparam logic [1:0] MOT_PARA   = 2'b00;
    localparam logic [1:0] MOT_FRENTE = 2'b01;
    localparam logic [1:0] MOT_RE     = 2'b10;

    localparam logic [1:0] BRACO_PARA  = 2'b00;
    localparam logic [1:0] BRACO_DESCE = 2'b01;
    localparam logic [1:0] BRACO_SOBE  = 2'b10;

endpackage

// File: rtl/controle_atuadores_temporizador.sv
// temporizador_descendente: loadable down-counter that parks at zero and flags it
module temporizador_descendente #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          carrega,
    input  logic [CW-1:0] valor,
    output logic          zero
);

    logic [CW-1:0] r_cnt;

    // Load takes precedence; otherwise count down and hold at zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (carrega)
            r_cnt <= valor;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/controle_atuadores.sv
// controle_atuadores: arbitrates navigation requests into timed actuator sequences; CONTADOR_REMOCOES_EN adds a removal counter
module controle_atuadores
    import controle_pkg::*;
#(
    parameter int T_AVANCA = 8,
    parameter int T_GIRA   = 4,
    parameter int T_BRACO  = 6,
    parameter int T_VARRE  = 10,
    parameter int CW       = 8
) (
    input  logic       clockc2,
    input  logic       reset,
    input  logic       avancar,
    input  logic       girar,
    input  logic       remover,
    output logic [1:0] mot_esq,
    output logic [1:0] mot_dir,
    output logic [1:0] braco,
    output logic       varre,
    output logic       ocupado,
    output logic       cmd_ack,
    output logic       concluido
`ifdef CONTADOR_REMOCOES_EN
    ,
    output logic [7:0] n_remocoes
`endif
);

    localparam logic [CW-1:0] V_AVANCA = CW'(T_AVANCA - 1);
    localparam logic [CW-1:0] V_GIRA   = CW'(T_GIRA - 1);
    localparam logic [CW-1:0] V_BRACO  = CW'(T_BRACO - 1);
    localparam logic [CW-1:0] V_VARRE  = CW'(T_VARRE - 1);

    estado_t       r_estado;
    estado_t       w_prox;
    logic          w_carrega;
    logic [CW-1:0] w_valor;
    logic          w_zero;

    temporizador_descendente #(.CW(CW)) u_tempo (
        .clk     (clockc2),
        .rst_n   (reset),
        .carrega (w_carrega),
        .valor   (w_valor),
        .zero    (w_zero)
    );

    // Next state plus the counter reload issued on entry to each timed state
    always_comb begin
        w_prox    = r_estado;
        w_carrega = 1'b0;
        w_valor   = '0;
        case (r_estado)
            E_OCIOSO:
                if (remover) begin
                    w_prox    = E_BRACO_DESCE;
                    w_carrega = 1'b1;
                    w_valor   = V_BRACO;
                end else if (girar) begin
                    w_prox    = E_GIRA;
                    w_carrega = 1'b1;
                    w_valor   = V_GIRA;
                end else if (avancar) begin
                    w_prox    = E_AVANCA;
                    w_carrega = 1'b1;
                    w_valor   = V_AVANCA;
                end
            E_AVANCA, E_GIRA, E_BRACO_SOBE:
                if (w_zero) w_prox = E_PAUSA;
            E_BRACO_DESCE:
                if (w_zero) begin
                    w_prox    = E_VARRE;
                    w_carrega = 1'b1;
                    w_valor   = V_VARRE;
                end
            E_VARRE:
                if (w_zero) begin
                    w_prox    = E_BRACO_SOBE;
                    w_carrega = 1'b1;
                    w_valor   = V_BRACO;
                end
            E_PAUSA:
                w_prox = E_OCIOSO;
            default:
                w_prox = E_OCIOSO;
        endcase
    end

    // State and outputs advance together, outputs decoded from the state being entered
    always_ff @(posedge clockc2 or negedge reset)
        if (!reset) begin
            r_estado  <= E_OCIOSO;
            mot_esq   <= MOT_PARA;
            mot_dir   <= MOT_PARA;
            braco     <= BRACO_PARA;
            varre     <= 1'b0;
            ocupado   <= 1'b0;
            cmd_ack   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            mot_esq   <= (w_prox == E_AVANCA || w_prox == E_GIRA) ? MOT_FRENTE : MOT_PARA;
            mot_dir   <= (w_prox == E_AVANCA) ? MOT_FRENTE : (w_prox == E_GIRA) ? MOT_RE : MOT_PARA;
            braco     <= (w_prox == E_BRACO_DESCE) ? BRACO_DESCE : (w_prox == E_BRACO_SOBE) ? BRACO_SOBE : BRACO_PARA;
            varre     <= (w_prox == E_VARRE);
            ocupado   <= (w_prox != E_OCIOSO);
            cmd_ack   <= (r_estado == E_OCIOSO) && (w_prox != E_OCIOSO);
            concluido <= (w_prox == E_PAUSA);
        end

`ifdef CONTADOR_REMOCOES_EN
    // Count completed removals, saturating rather than wrapping
    always_ff @(posedge clockc2 or negedge reset)
        if (!reset)
            n_remocoes <= '0;
        else if (r_estado == E_BRACO_SOBE && w_prox == E_PAUSA && n_remocoes != 8'hFF)
            n_remocoes <= n_remocoes + 1'b1;
`endif

endmodule

// File: tb/tb_controle_atuadores.sv
// tb_controle_atuadores: directed checks of arbitration, sequence timing and reset behaviour
module tb_controle_atuadores;

    logic       clockc2 = 1'b0;
    logic       reset   = 1'b0;
    logic       avancar = 1'b0;
    logic       girar   = 1'b0;
    logic       remover = 1'b0;
    logic [1:0] mot_esq, mot_dir, braco;
    logic       varre, ocupado, cmd_ack, concluido;
`ifdef CONTADOR_REMOCOES_EN
    logic [7:0] n_remocoes;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clockc2 = ~clockc2;

    controle_atuadores dut (
        .clockc2   (clockc2),
        .reset     (reset),
        .avancar   (avancar),
        .girar     (girar),
        .remover   (remover),
        .mot_esq   (mot_esq),
        .mot_dir   (mot_dir),
        .braco     (braco),
        .varre     (varre),
        .ocupado   (ocupado),
        .cmd_ack   (cmd_ack),
        .concluido (concluido)
`ifdef CONTADOR_REMOCOES_EN
        ,
        .n_remocoes(n_remocoes)
`endif
    );

    task automatic step();
        @(posedge clockc2);
        #1;
    endtask

    task automatic idle(input int n);
        avancar = 1'b0;
        girar   = 1'b0;
        remover = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({mot_esq, mot_dir, braco, varre, ocupado, cmd_ack, concluido} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {mot_esq, mot_dir, braco, varre, ocupado, cmd_ack, concluido});
        end
        step();
        step();
        reset = 1'b1;
        idle(2);
        checks++;
        if (ocupado !== 1'b0 || cmd_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle ocupado=%b cmd_ack=%b want 0 0", ocupado, cmd_ack);
        end
    endtask

    task automatic test_avancar();
        int n_fwd = 0, n_ack = 0, n_conc = 0, n_busy = 0;
        avancar = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            avancar = 1'b0;
            if (mot_esq == 2'b01 && mot_dir == 2'b01) n_fwd++;
            if (cmd_ack) n_ack++;
            if (concluido) n_conc++;
            if (ocupado) n_busy++;
            if (i == 0) begin
                checks++;
                if (cmd_ack !== 1'b1 || mot_esq !== 2'b01 || mot_dir !== 2'b01) begin
                    errors++;
                    $display("FAIL avancar_first ack=%b esq=%b dir=%b want 1 01 01", cmd_ack, mot_esq, mot_dir);
                end
            end
            if (i == 8) begin
                checks++;
                if (concluido !== 1'b1 || mot_esq !== 2'b00 || ocupado !== 1'b1) begin
                    errors++;
                    $display("FAIL avancar_pausa conc=%b esq=%b ocup=%b want 1 00 1", concluido, mot_esq, ocupado);
                end
            end
        end
        checks++;
        if (n_fwd != 8 || n_ack != 1 || n_conc != 1 || n_busy != 9) begin
            errors++;
            $display("FAIL avancar_counts fwd=%0d ack=%0d conc=%0d busy=%0d want 8 1 1 9", n_fwd, n_ack, n_conc, n_busy);
        end
    endtask

    task automatic test_prioridade();
        int n_desce = 0, n_varre = 0, n_sobe = 0, n_mot = 0, n_ack = 0, conc_at = -1;
        avancar = 1'b1;
        girar   = 1'b1;
        remover = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            avancar = 1'b0;
            girar   = 1'b0;
            remover = 1'b0;
            if (braco == 2'b01) n_desce++;
            if (braco == 2'b10) n_sobe++;
            if (varre) n_varre++;
            if (mot_esq != 2'b00 || mot_dir != 2'b00) n_mot++;
            if (cmd_ack) n_ack++;
            if (concluido && conc_at < 0) conc_at = i;
            if (i == 0 || i == 6 || i == 16) begin
                checks++;
                if ((i == 0 && braco !== 2'b01) || (i == 6 && varre !== 1'b1) || (i == 16 && braco !== 2'b10)) begin
                    errors++;
                    $display("FAIL prio_phase idx=%0d braco=%b varre=%b", i, braco, varre);
                end
            end
        end
        checks++;
        if (n_desce != 6 || n_varre != 10 || n_sobe != 6) begin
            errors++;
            $display("FAIL prio_durations desce=%0d varre=%0d sobe=%0d want 6 10 6", n_desce, n_varre, n_sobe);
        end
        checks++;
        if (conc_at != 22 || n_ack != 1 || n_mot != 0) begin
            errors++;
            $display("FAIL prio_end conc_at=%0d ack=%0d mot=%0d want 22 1 0", conc_at, n_ack, n_mot);
        end
    endtask

    task automatic test_girar_durante();
        int ack_at = -1, n_re = 0, n_ack = 0;
        avancar = 1'b1;
        for (int i = 0; i < 19; i++) begin
            step();
            avancar = 1'b0;
            if (cmd_ack) n_ack++;
            if (cmd_ack && i > 0 && ack_at < 0) ack_at = i;
            if (mot_dir == 2'b10) n_re++;
            if (i == 2) girar = 1'b1;
            if (i == 10) girar = 1'b0;
        end
        checks++;
        if (ack_at != 10 || n_ack != 2) begin
            errors++;
            $display("FAIL girar_accept at=%0d acks=%0d want 10 2", ack_at, n_ack);
        end
        checks++;
        if (n_re != 4) begin
            errors++;
            $display("FAIL girar_duration got=%0d want 4", n_re);
        end
    endtask

    task automatic test_reset_assincrono();
        int n_conc = 0;
        remover = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            remover = 1'b0;
            if (concluido) n_conc++;
        end
        checks++;
        if (varre !== 1'b1) begin
            errors++;
            $display("FAIL async_pre varre=%b want 1", varre);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({mot_esq, mot_dir, braco, varre, ocupado, cmd_ack, concluido} !== 10'b0) begin
            errors++;
            $display("FAIL async_clear got=%b want=0", {mot_esq, mot_dir, braco, varre, ocupado, cmd_ack, concluido});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (concluido) n_conc++;
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (concluido) n_conc++;
        end
        checks++;
        if (n_conc != 0) begin
            errors++;
            $display("FAIL async_no_concluido got=%0d want 0", n_conc);
        end
        remover = 1'b1;
        step();
        remover = 1'b0;
        checks++;
        if (cmd_ack !== 1'b1 || braco !== 2'b01 || varre !== 1'b0) begin
            errors++;
            $display("FAIL async_restart ack=%b braco=%b varre=%b want 1 01 0", cmd_ack, braco, varre);
        end
`ifdef CONTADOR_REMOCOES_EN
        checks++;
        if (n_remocoes !== 8'd0) begin
            errors++;
            $display("FAIL async_counter got=%0d want 0", n_remocoes);
        end
`endif
        idle(26);
    endtask

    task automatic test_back_to_back();
        logic [29:0] acks = '0;
        avancar = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            acks[i] = cmd_ack;
        end
        avancar = 1'b0;
        checks++;
        if (acks !== 30'h0010_0401) begin
            errors++;
            $display("FAIL back_to_back acks=%h want 00100401", acks);
        end
        idle(12);
    endtask

`ifdef CONTADOR_REMOCOES_EN
    task automatic test_contador();
        int n_ack = 0;
        remover = 1'b1;
        for (int i = 0; i < 257 * 24 + 100 && n_ack < 257; i++) begin
            step();
            if (cmd_ack) n_ack++;
        end
        remover = 1'b0;
        idle(30);
        checks++;
        if (n_ack != 257 || n_remocoes !== 8'd255) begin
            errors++;
            $display("FAIL counter_saturate acks=%0d n=%0d want 257 255", n_ack, n_remocoes);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_avancar();
        idle(3);
        test_prioridade();
        idle(3);
        test_girar_durante();
        idle(3);
        test_reset_assincrono();
        test_back_to_back();
`ifdef CONTADOR_REMOCOES_EN
        test_contador();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
